uart_tx_burst_arbiter: RTL and testbench

//  Round-robin scheduler sharing one UART_TX instance between NUM_REQ byte-stream sources.

---
 rtl/uart_tx_burst_arbiter.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_burst_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_burst_arbiter.sv
// Round-robin burst scheduler that shares one UART transmitter between NUM_REQ byte sources.
// One requester owns the UART for a whole burst; bytes are paced one frame apart, bursts separated by an idle gap.
module uart_tx_burst_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FRAME_CLKS = 20,
    parameter int GAP_CLKS   = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*10-1:0] req_len,
    input  logic [NUM_REQ*8-1:0]  req_data,
    output logic [NUM_REQ-1:0]    data_ack,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  burst_done,
    output logic                  busy,
    output logic [9:0]            bytes_to_tx,
    output logic [7:0]            tx_data_byte,
    output logic                  tx_data_valid
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int FW = $clog2(FRAME_CLKS + 1);
    localparam int GW = $clog2(GAP_CLKS + 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

    state_t               state_r, state_s;
    logic [IW-1:0]        ptr_r, ptr_s, sel_r, sel_s, pick_s, idx_s;
    logic                 found_s;
    logic [9:0]           remaining_r, remaining_s;
    logic [FW-1:0]        frame_r, frame_s;
    logic [GW-1:0]        gap_r, gap_s;
    logic [NUM_REQ-1:0]   grant_r, grant_s, ack_r, ack_s;
    logic                 done_r, done_s, busy_r, busy_s, valid_r, valid_s;
    logic [9:0]           bytes_r, bytes_s;
    logic [7:0]           byte_r, byte_s;
    logic [9:0]           len_arr [NUM_REQ];
    logic [7:0]           data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
        assign len_arr[g]  = req_len[g*10 +: 10];
        assign data_arr[g] = req_data[g*8 +: 8];
    end

    // Round-robin pick: first active request at or after the rotation pointer.
    always_comb begin
        found_s = 1'b0;
        pick_s  = {IW{1'b0}};
        idx_s   = {IW{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s = IW'((int'(ptr_r) + k) % NUM_REQ);
            if (!found_s && req[idx_s]) begin
                found_s = 1'b1;
                pick_s  = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and next-output logic for the burst FSM.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        sel_s       = sel_r;
        remaining_s = remaining_r;
        frame_s     = frame_r;
        gap_s       = gap_r;
        grant_s     = grant_r;
        bytes_s     = bytes_r;
        byte_s      = byte_r;
        valid_s     = valid_r;
        ack_s       = {NUM_REQ{1'b0}};
        done_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    sel_s       = pick_s;
                    ptr_s       = IW'((int'(pick_s) + 1) % NUM_REQ);
                    grant_s     = ONE_HOT0 << pick_s;
                    bytes_s     = len_arr[pick_s];
                    remaining_s = len_arr[pick_s];
                    if (len_arr[pick_s] == 10'd0) begin
                        // Empty burst: nothing to send, but the slot is consumed.
                        done_s  = 1'b1;
                        gap_s   = GW'(GAP_CLKS - 1);
                        state_s = GAP;
                    end else begin
                        state_s = LOAD;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                byte_s  = data_arr[sel_r];
                ack_s   = ONE_HOT0 << sel_r;
                valid_s = 1'b1;
                frame_s = FW'(FRAME_CLKS - 1);
                state_s = SEND;
            end
            SEND: begin
                if (frame_r == {FW{1'b0}}) begin
                    remaining_s = (remaining_r != 10'd0) ? (remaining_r - 10'd1) : remaining_r;
                    if (remaining_r <= 10'd1) begin
                        done_s  = 1'b1;
                        valid_s = 1'b0;
                        grant_s = {NUM_REQ{1'b0}};
                        gap_s   = GW'(GAP_CLKS - 1);
                        state_s = GAP;
                    end else begin
                        state_s = LOAD;
                    end
                end else begin
                    frame_s = frame_r - FW'(1);
                end
            end
            GAP: begin
                grant_s = {NUM_REQ{1'b0}};
                valid_s = 1'b0;
                if (gap_r == {GW{1'b0}}) begin
                    state_s = IDLE;
                end else begin
                    gap_s = gap_r - GW'(1);
                end
            end
            default: begin
                state_s = IDLE;
                grant_s = {NUM_REQ{1'b0}};
                valid_s = 1'b0;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and registered outputs; reset forces everything idle and the pointer to requester 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            ptr_r       <= {IW{1'b0}};
            sel_r       <= {IW{1'b0}};
            remaining_r <= 10'd0;
            frame_r     <= {FW{1'b0}};
            gap_r       <= {GW{1'b0}};
            grant_r     <= {NUM_REQ{1'b0}};
            ack_r       <= {NUM_REQ{1'b0}};
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            bytes_r     <= 10'd0;
            byte_r      <= 8'd0;
            valid_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            sel_r       <= sel_s;
            remaining_r <= remaining_s;
            frame_r     <= frame_s;
            gap_r       <= gap_s;
            grant_r     <= grant_s;
            ack_r       <= ack_s;
            done_r      <= done_s;
            busy_r      <= busy_s;
            bytes_r     <= bytes_s;
            byte_r      <= byte_s;
            valid_r     <= valid_s;
        end
    end

    assign data_ack      = ack_r;
    assign grant         = grant_r;
    assign burst_done    = done_r;
    assign busy          = busy_r;
    assign bytes_to_tx   = bytes_r;
    assign tx_data_byte  = byte_r;
    assign tx_data_valid = valid_r;

endmodule

// File: tb/tb_uart_tx_burst_arbiter.sv
// Directed bench for uart_tx_burst_arbiter (NUM_REQ=4, FRAME_CLKS=20, GAP_CLKS=4).
// Timing expectations are hand-derived: grant at cycle 1, ack at 2, acks 21 apart, burst period len*21+5.
module tb_uart_tx_burst_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [39:0] req_len;
    logic [31:0] req_data;
    logic [3:0]  data_ack;
    logic [3:0]  grant;
    logic        burst_done;
    logic        busy;
    logic [9:0]  bytes_to_tx;
    logic [7:0]  tx_data_byte;
    logic        tx_data_valid;

    int checks = 0;
    int errors = 0;

    logic [7:0] data_tab [4][8];
    int nxt [4];
    int cyc, ng, na, nd, nvalid, ghi, viol, last_g;
    int g_cyc [16];
    int g_idx [16];
    int a_cyc [16];
    int a_idx [16];
    int d_cyc [16];
    logic [7:0] a_byte [16];
    logic [3:0] prev_grant;

    uart_tx_burst_arbiter dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req           (req),
        .req_len       (req_len),
        .req_data      (req_data),
        .data_ack      (data_ack),
        .grant         (grant),
        .burst_done    (burst_done),
        .busy          (busy),
        .bytes_to_tx   (bytes_to_tx),
        .tx_data_byte  (tx_data_byte),
        .tx_data_valid (tx_data_valid)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int oh2idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic clear_log();
        cyc = 0; ng = 0; na = 0; nd = 0; nvalid = 0; ghi = 0; viol = 0; last_g = 0;
        prev_grant = grant;
        for (int i = 0; i < 4; i++) begin
            nxt[i] = 0;
            req_data[i*8 +: 8] = data_tab[i][0];
        end
    endtask

    // Requester model and event recorder: samples at negedge, feeds the next byte on each ack.
    task automatic run(input int n, input bit drop_on_done);
        int i;
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            cyc++;
            if (grant != 4'd0) ghi++;
            if ((grant & (grant - 4'd1)) != 4'd0) viol++;
            if ((data_ack & ~grant) != 4'd0) viol++;
            if (grant != 4'd0 && prev_grant == 4'd0 && ng < 16) begin
                g_cyc[ng] = cyc;
                g_idx[ng] = oh2idx(grant);
                last_g = g_idx[ng];
                ng++;
            end
            prev_grant = grant;
            if (data_ack != 4'd0 && na < 16) begin
                i = oh2idx(data_ack);
                a_cyc[na] = cyc;
                a_idx[na] = i;
                a_byte[na] = tx_data_byte;
                na++;
                if (i >= 0) begin
                    nxt[i] = nxt[i] + 1;
                    req_data[i*8 +: 8] = data_tab[i][nxt[i] % 8];
                end
            end
            if (burst_done && nd < 16) begin
                d_cyc[nd] = cyc;
                nd++;
                if (drop_on_done) req[last_g] = 1'b0;
            end
            if (tx_data_valid) nvalid++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req = 4'd0; req_len = 40'd0; req_data = 32'd0;
        repeat (3) @(negedge clock);
        checks++; if (grant !== 4'd0) begin $display("FAIL rst_grant: got %h expected 0", grant); errors++; end
        checks++; if (data_ack !== 4'd0) begin $display("FAIL rst_ack: got %h expected 0", data_ack); errors++; end
        checks++; if (busy !== 1'b0 || burst_done !== 1'b0) begin $display("FAIL rst_busy_done: got %b%b expected 00", busy, burst_done); errors++; end
        checks++; if (bytes_to_tx !== 10'd0 || tx_data_byte !== 8'd0 || tx_data_valid !== 1'b0) begin
            $display("FAIL rst_tx: got len=%0d byte=%h valid=%b expected 0", bytes_to_tx, tx_data_byte, tx_data_valid); errors++; end
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        checks++; if (busy !== 1'b0 || grant !== 4'd0) begin $display("FAIL rst_idle: got busy=%b grant=%h expected 0", busy, grant); errors++; end
    endtask

    task automatic test_contention();
        clear_log();
        req_len = {10'd1, 10'd1, 10'd1, 10'd1};
        req = 4'b1111;
        run(110, 1'b1);
        checks++; if (ng !== 4) begin $display("FAIL cont_ngrant: got %0d expected 4", ng); errors++; end
        checks++; if (na !== 4) begin $display("FAIL cont_nack: got %0d expected 4", na); errors++; end
        for (int k = 0; k < 4; k++) begin
            checks++; if (g_idx[k] !== k || g_cyc[k] !== 1 + 26*k) begin
                $display("FAIL cont_grant%0d: got idx=%0d cyc=%0d expected idx=%0d cyc=%0d", k, g_idx[k], g_cyc[k], k, 1 + 26*k); errors++; end
            checks++; if (a_idx[k] !== k || a_cyc[k] !== 2 + 26*k || a_byte[k] !== data_tab[k][0]) begin
                $display("FAIL cont_ack%0d: got idx=%0d cyc=%0d byte=%h expected %0d %0d %h", k, a_idx[k], a_cyc[k], a_byte[k], k, 2 + 26*k, data_tab[k][0]); errors++; end
            checks++; if (d_cyc[k] !== 22 + 26*k) begin $display("FAIL cont_done%0d: got %0d expected %0d", k, d_cyc[k], 22 + 26*k); errors++; end
        end
        checks++; if (nvalid !== 80) begin $display("FAIL cont_valid: got %0d expected 80", nvalid); errors++; end
        checks++; if (viol !== 0) begin $display("FAIL cont_onehot: got %0d expected 0", viol); errors++; end
    endtask

    task automatic test_single();
        clear_log();
        req_len = {10'd0, 10'd0, 10'd0, 10'd3};
        req = 4'b0001;
        run(90, 1'b1);
        checks++; if (ng !== 1 || g_cyc[0] !== 1 || g_idx[0] !== 0) begin
            $display("FAIL single_grant: got n=%0d cyc=%0d idx=%0d expected 1 1 0", ng, g_cyc[0], g_idx[0]); errors++; end
        checks++; if (na !== 3) begin $display("FAIL single_nack: got %0d expected 3", na); errors++; end
        for (int k = 0; k < 3; k++) begin
            checks++; if (a_cyc[k] !== 2 + 21*k || a_byte[k] !== data_tab[0][k]) begin
                $display("FAIL single_ack%0d: got cyc=%0d byte=%h expected %0d %h", k, a_cyc[k], a_byte[k], 2 + 21*k, data_tab[0][k]); errors++; end
        end
        checks++; if (nd !== 1 || d_cyc[0] !== 64) begin $display("FAIL single_done: got n=%0d cyc=%0d expected 1 64", nd, d_cyc[0]); errors++; end
        checks++; if (nvalid !== 62) begin $display("FAIL single_valid: got %0d expected 62", nvalid); errors++; end
        checks++; if (bytes_to_tx !== 10'd3 || busy !== 1'b0) begin
            $display("FAIL single_hold: got len=%0d busy=%b expected 3 0", bytes_to_tx, busy); errors++; end
    endtask

    task automatic test_zero_length();
        clear_log();
        req_len = {10'd0, 10'd0, 10'd0, 10'd0};
        req = 4'b0010;
        run(20, 1'b1);
        checks++; if (ng !== 1 || g_idx[0] !== 1 || ghi !== 1) begin
            $display("FAIL zero_grant: got n=%0d idx=%0d width=%0d expected 1 1 1", ng, g_idx[0], ghi); errors++; end
        checks++; if (nd !== 1 || d_cyc[0] !== 1) begin $display("FAIL zero_done: got n=%0d cyc=%0d expected 1 1", nd, d_cyc[0]); errors++; end
        checks++; if (na !== 0 || nvalid !== 0) begin $display("FAIL zero_nodata: got acks=%0d valid=%0d expected 0 0", na, nvalid); errors++; end
        checks++; if (bytes_to_tx !== 10'd0) begin $display("FAIL zero_len: got %0d expected 0", bytes_to_tx); errors++; end
    endtask

    task automatic test_drop_req();
        clear_log();
        req_len = {10'd4, 10'd0, 10'd0, 10'd0};
        req = 4'b1000;
        run(2, 1'b0);
        req = 4'b0000;
        req_len[39:30] = 10'd1;
        run(100, 1'b0);
        checks++; if (ng !== 1 || g_idx[0] !== 3) begin $display("FAIL drop_grant: got n=%0d idx=%0d expected 1 3", ng, g_idx[0]); errors++; end
        checks++; if (na !== 4) begin $display("FAIL drop_nack: got %0d expected 4", na); errors++; end
        for (int k = 0; k < 4; k++) begin
            checks++; if (a_cyc[k] !== 2 + 21*k || a_byte[k] !== data_tab[3][k] || a_idx[k] !== 3) begin
                $display("FAIL drop_ack%0d: got cyc=%0d byte=%h expected %0d %h", k, a_cyc[k], a_byte[k], 2 + 21*k, data_tab[3][k]); errors++; end
        end
        checks++; if (nd !== 1 || d_cyc[0] !== 85) begin $display("FAIL drop_done: got n=%0d cyc=%0d expected 1 85", nd, d_cyc[0]); errors++; end
        checks++; if (nvalid !== 83 || bytes_to_tx !== 10'd4) begin
            $display("FAIL drop_valid: got valid=%0d len=%0d expected 83 4", nvalid, bytes_to_tx); errors++; end
    endtask

    task automatic test_rotation();
        int exp_i;
        clear_log();
        req_len = {10'd0, 10'd2, 10'd0, 10'd2};
        req = 4'b0101;
        run(184, 1'b0);
        req = 4'b0000;
        run(20, 1'b0);
        checks++; if (ng !== 4 || nd !== 4 || na !== 8) begin
            $display("FAIL rot_counts: got grants=%0d dones=%0d acks=%0d expected 4 4 8", ng, nd, na); errors++; end
        for (int k = 0; k < 4; k++) begin
            exp_i = (k % 2 == 1) ? 2 : 0;
            checks++; if (g_idx[k] !== exp_i || g_cyc[k] !== 1 + 47*k || d_cyc[k] !== 43 + 47*k) begin
                $display("FAIL rot_burst%0d: got idx=%0d cyc=%0d done=%0d expected %0d %0d %0d", k, g_idx[k], g_cyc[k], d_cyc[k], exp_i, 1 + 47*k, 43 + 47*k); errors++; end
        end
        for (int j = 0; j < 8; j++) begin
            exp_i = ((j / 2) % 2 == 1) ? 2 : 0;
            checks++; if (a_idx[j] !== exp_i || a_cyc[j] !== 2 + 47*(j/2) + 21*(j%2) || a_byte[j] !== data_tab[exp_i][(j/4)*2 + j%2]) begin
                $display("FAIL rot_ack%0d: got idx=%0d cyc=%0d byte=%h expected %0d %0d %h", j, a_idx[j], a_cyc[j], a_byte[j],
                         exp_i, 2 + 47*(j/2) + 21*(j%2), data_tab[exp_i][(j/4)*2 + j%2]); errors++; end
        end
        checks++; if (ghi !== 168 || nvalid !== 164 || viol !== 0) begin
            $display("FAIL rot_shape: got grant_cycles=%0d valid=%0d viol=%0d expected 168 164 0", ghi, nvalid, viol); errors++; end
    endtask

    task automatic test_reset_mid_send();
        clear_log();
        req_len = {10'd0, 10'd5, 10'd0, 10'd0};
        req = 4'b0100;
        run(10, 1'b0);
        checks++; if (g_idx[0] !== 2 || tx_data_valid !== 1'b1) begin
            $display("FAIL midrst_pre: got idx=%0d valid=%b expected 2 1", g_idx[0], tx_data_valid); errors++; end
        reset_n = 1'b0;
        #1;
        checks++; if (grant !== 4'd0 || busy !== 1'b0 || bytes_to_tx !== 10'd0 || tx_data_byte !== 8'd0 || tx_data_valid !== 1'b0) begin
            $display("FAIL midrst_outputs: got grant=%h busy=%b len=%0d byte=%h valid=%b expected all 0",
                     grant, busy, bytes_to_tx, tx_data_byte, tx_data_valid); errors++; end
        req = 4'b1010;
        req_len = {10'd1, 10'd0, 10'd1, 10'd0};
        repeat (2) @(negedge clock);
        clear_log();
        reset_n = 1'b1;
        run(60, 1'b1);
        checks++; if (ng !== 2 || g_idx[0] !== 1 || g_cyc[0] !== 1 || g_idx[1] !== 3) begin
            $display("FAIL midrst_ptr: got n=%0d first=%0d at %0d second=%0d expected 2 1 1 3", ng, g_idx[0], g_cyc[0], g_idx[1]); errors++; end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            for (int n = 0; n < 8; n++) begin
                data_tab[i][n] = 8'(32*i + n + 1);
            end
        end
        data_tab[0][0] = 8'hEE;
        data_tab[0][1] = 8'h93;
        data_tab[0][2] = 8'hD7;
        test_reset();
        test_contention();
        test_single();
        test_zero_length();
        test_drop_req();
        test_rotation();
        test_reset_mid_send();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
